// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of the sequencer: memory handshake, ARF/IR control strobes
// and the valid/ready hand-off of the fetched instruction to execute.
interface fetch_sequencer_if;
   logic       mem_req;
   logic       mem_ack;
   logic [1:0] arf_outasel;
   logic [1:0] arf_funsel;
   logic [3:0] arf_rsel;
   logic       ir_enable;
   logic [1:0] ir_funsel;
   logic       ir_lh;
   logic       instr_valid;
   logic       instr_ready;

   modport master (
      output mem_req, arf_outasel, arf_funsel, arf_rsel,
             ir_enable, ir_funsel, ir_lh, instr_valid,
      input  mem_ack, instr_ready
   );

   modport slave (
      input  mem_req, arf_outasel, arf_funsel, arf_rsel,
             ir_enable, ir_funsel, ir_lh, instr_valid,
      output mem_ack, instr_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads two bytes at PC into IR (low then high),
// bumps PC per byte and offers the finished word to execute via valid/ready.
module fetch_sequencer #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              pc_clr_i,
   input  logic              halt_i,
   fetch_sequencer_if.master bus,
   output logic              busy_o,
   output logic              err_o,
   output logic [2:0]        state_dbg_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR    = 3'd1,
      S_REQ_LO = 3'd2,
      S_REQ_HI = 3'd3,
      S_ISSUE  = 3'd4,
      S_ERR    = 3'd5
   } state_e;

   localparam logic [1:0] FUN_CLR  = 2'b00;
   localparam logic [1:0] FUN_LOAD = 2'b01;
   localparam logic [1:0] FUN_INC  = 2'b11;
   localparam logic [1:0] SEL_PC   = 2'b11;
   localparam logic [3:0] RSEL_PC  = 4'b0001;
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halt_pending_q, halt_pending_d;
   logic             err_q, err_d;
   logic             in_req;
   logic             timeout;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         halt_pending_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         halt_pending_q <= halt_pending_d;
         err_q          <= err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   assign in_req  = (state_q == S_REQ_LO) || (state_q == S_REQ_HI);
   // The count about to become TIMEOUT marks the last cycle an ack is accepted.
   assign timeout = (cnt_q == LAST_WAIT);

   always_comb begin
      // NOTE: every variable assigned here gets a default first so no latch is inferred.
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_i) state_d = pc_clr_i ? S_CLR : S_REQ_LO;
         S_CLR:    state_d = S_REQ_LO;
         S_REQ_LO: begin
            if (bus.mem_ack)  state_d = S_REQ_HI;
            else if (timeout) state_d = S_ERR;
         end
         S_REQ_HI: begin
            if (bus.mem_ack)  state_d = S_ISSUE;
            else if (timeout) state_d = S_ERR;
         end
         S_ISSUE:  if (bus.instr_ready) state_d = halt_pending_q ? S_IDLE : S_REQ_LO;
         S_ERR:    state_d = S_ERR;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = (in_req && !bus.mem_ack) ? cnt_q + 1'b1 : '0;

      halt_pending_d = halt_pending_q;
      if (state_d == S_IDLE) halt_pending_d = 1'b0;
      else if (halt_i)       halt_pending_d = 1'b1;

      err_d = err_q | (state_d == S_ERR);
   end

   // ---------------------------------------------------------------------
   // Output logic (Mealy on mem_ack so the byte lands on the ack edge)
   // ---------------------------------------------------------------------
   always_comb begin
      bus.mem_req     = 1'b0;
      bus.arf_outasel = 2'b00;
      bus.arf_funsel  = FUN_CLR;
      bus.arf_rsel    = 4'b0000;
      bus.ir_enable   = 1'b0;
      bus.ir_funsel   = FUN_CLR;
      bus.ir_lh       = 1'b0;
      bus.instr_valid = 1'b0;
      busy_o          = (state_q != S_IDLE) && (state_q != S_ERR);
      err_o           = err_q;
      state_dbg_o     = state_q;

      case (state_q)
         S_CLR: begin
            bus.arf_rsel  = RSEL_PC;
            bus.ir_enable = 1'b1;
         end
         S_REQ_LO, S_REQ_HI: begin
            bus.mem_req     = 1'b1;
            bus.arf_outasel = SEL_PC;
            bus.ir_lh       = (state_q == S_REQ_HI);
            if (bus.mem_ack) begin
               bus.ir_enable  = 1'b1;
               bus.ir_funsel  = FUN_LOAD;
               bus.arf_rsel   = RSEL_PC;
               bus.arf_funsel = FUN_INC;
            end
         end
         S_ISSUE: bus.instr_valid = 1'b1;
         default: ;
      endcase

      // NOTE: reset is synchronous, so outputs are gated here to keep PC/IR untouched in the reset cycle.
      if (rst) begin
         bus.mem_req     = 1'b0;
         bus.arf_outasel = 2'b00;
         bus.arf_funsel  = 2'b00;
         bus.arf_rsel    = 4'b0000;
         bus.ir_enable   = 1'b0;
         bus.ir_funsel   = 2'b00;
         bus.ir_lh       = 1'b0;
         bus.instr_valid = 1'b0;
         busy_o          = 1'b0;
         err_o           = 1'b0;
         state_dbg_o     = 3'd0;
      end
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Sequences instruction fetch for the datapath: drives the `arf` control inputs (PC select and increment) and the `ir` control inputs (byte load, low/high).
- Runs a memory request/acknowledge handshake and hands each completed 16-bit instruction to the execute stage through a valid/ready handshake.
- Sits between the memory port and the ARF/IR pair, and is the only writer of PC and IR during fetch.

## Interface
Parameters:
- TIMEOUT, 15, maximum consecutive un-acknowledged request cycles before error (1..2^CNT_W-1)
- CNT_W, 4, width of the wait counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin fetching (honoured only in IDLE)
- pc_clr  in  1  sampled with start; 1 = clear PC and IR before the first fetch
- halt  in  1  stop after the instruction in flight is issued
- mem_req  out  1  memory read request; the address is ARF outa (PC)
- mem_ack  in  1  memory data byte valid this cycle
- arf_outasel  out  2  ARF outa select; 2'b11 = PC
- arf_funsel  out  2  ARF funsel: 00 clear, 01 load, 10 decrement, 11 increment
- arf_rsel  out  4  ARF enables; bit0 = PC
- ir_enable  out  1  IR enable
- ir_funsel  out  2  IR funsel (same encoding as ARF)
- ir_lh  out  1  IR byte select: 0 = [7:0], 1 = [15:8]
- instr_valid  out  1  IR holds a complete instruction
- instr_ready  in  1  execute stage accepts the instruction
- busy  out  1  state is not IDLE and not ERR
- err  out  1  sticky memory timeout flag
- state_dbg  out  3  current state encoding

## Operation
- States and encodings: IDLE=0, CLR=1, REQ_LO=2, REQ_HI=3, ISSUE=4, ERR=5. Encodings 6 and 7 are illegal and return to IDLE.
- **IDLE**: all controls inactive.
  - start=1 and pc_clr=1 → CLR.
  - start=1 and pc_clr=0 → REQ_LO.
- **CLR** (1 cycle): arf_rsel=0001 and arf_funsel=00; ir_enable=1 and ir_funsel=00. → REQ_LO.
- **REQ_LO**: mem_req=1, arf_outasel=11.
  - In any cycle with mem_ack=1: ir_enable=1, ir_funsel=01, ir_lh=0; arf_rsel=0001, arf_funsel=11 (PC+1). → REQ_HI.
- **REQ_HI**: same as REQ_LO with ir_lh=1. On mem_ack → ISSUE.
- **ISSUE**: instr_valid=1, mem_req=0. When instr_ready=1:
  - halt pending → IDLE.
  - otherwise → REQ_LO.
- **ERR**: err=1, everything else inactive. Left only by rst.
- Wait counter:
  - Cleared on entry to REQ_LO/REQ_HI.
  - Increments each REQ cycle with mem_ack=0.
  - When it reaches TIMEOUT with mem_ack=0, the next state is ERR.
  - An ack in the TIMEOUT-th cycle is still accepted.
- halt_pending:
  - Set by halt=1 in any non-IDLE cycle, or in IDLE in the same cycle as an accepted start.
  - Cleared on entry to IDLE.
  - halt alone in IDLE is ignored.
- start and pc_clr are ignored outside IDLE. mem_ack is ignored outside REQ_LO/REQ_HI.
- In all states other than those listed above: arf_rsel=0000, ir_enable=0, arf_funsel=00, ir_funsel=00, ir_lh=0, arf_outasel=00.

## Timing
- Register state: state, wait counter, halt_pending, err.
- Mealy outputs: the ARF/IR/mem controls are combinational from state and mem_ack, so the byte is written at the same rising edge on which mem_ack is sampled high.
- Combinational output forcing: while rst=1, every output is forced to 0 in the same cycle, so no register is written during reset.
- Reset values: state=IDLE, counter=0, halt_pending=0, err=0; all outputs 0.
- Reset mid-fetch abandons the instruction. PC keeps any increments already committed.
- Best-case throughput is 3 cycles per instruction (REQ_LO, REQ_HI, ISSUE) with mem_ack and instr_ready tied high.
- Each wait cycle on mem_ack or instr_ready adds exactly one cycle.
- PC advances by exactly 2 per issued instruction. It wraps 8'hFF→8'h00 with no flag.

## Test plan
- **Clear then fetch**: rst, then start=1 with pc_clr=1, mem_ack tied high, bytes 8'hA5 then 8'h3C → CLR clears PC/IR; instr_valid in cycle 4 after start with IR=16'h3CA5 and PC=2.
- **Back-to-back throughput**: mem_ack=1 and instr_ready=1 for 10 instructions → instr_valid every 3rd cycle; PC=20 at the end; mem_req low only in ISSUE.
- **Stalls**: mem_ack delayed 4 cycles on the low byte and instr_ready delayed 2 cycles → IR/ARF enables pulse exactly once per ack; instruction issued 6 cycles later than best case.
- **Timeout**: TIMEOUT=15, mem_ack held 0 → ERR after 15 REQ cycles with err=1 and mem_req=0. Ack on cycle 15 instead → REQ_HI, no error. err clears only on rst.
- **Halt**: halt pulsed during REQ_HI → the current instruction issues, then IDLE, busy=0. Resume with start and pc_clr=0 → fetch continues at the retained PC.
- **Reset and wrap**: rst asserted in REQ_HI while mem_ack=1 → no IR/ARF enable that cycle; IDLE next cycle. Fetch with PC=8'hFE → next PC=8'h00.
